// File: rtl/lsu_byte_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_pkg
//  Brief    : Shared length encodings, sequencer state type and helpers for
//             the byte-wide load/store sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package lsu_pkg;

    // Request length encodings
    localparam logic [1:0] LEN_NONE = 2'b00;
    localparam logic [1:0] LEN_B    = 2'b01;
    localparam logic [1:0] LEN_H    = 2'b10;
    localparam logic [1:0] LEN_W    = 2'b11;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } lsu_state_e;

    // Number of single-byte memory transactions an access length needs
    function automatic logic [2:0] len_to_bytes(input logic [1:0] length);
        case (length)
            LEN_B:   return 3'd1;
            LEN_H:   return 3'd2;
            LEN_W:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_byte_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_byte_sequencer_if
//  Brief    : CPU request/response bus and byte-wide memory port of the
//             load/store sequencer. slave = sequencer side, master = the
//             CPU datapath plus memory that surround it.
//  Revision : 1.0  initial release
// ============================================================================
interface lsu_byte_sequencer_if #(
    parameter int ADDR_W     = 32,
    parameter int MEM_ADDR_W = 6
);
    // CPU side
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_W-1:0]     req_addr;
    logic [31:0]           req_wdata;
    logic [1:0]            req_length;
    logic                  req_signed;
    logic                  req_read;
    logic                  req_write;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    // Memory side
    logic [MEM_ADDR_W-1:0] byte_addr;
    logic [7:0]            byte_wdata;
    logic                  byte_we;
    logic                  byte_re;
    logic [7:0]            byte_rdata;

    modport slave (
        input  req_valid, req_addr, req_wdata, req_length, req_signed,
               req_read, req_write, byte_rdata,
        output req_ready, resp_valid, resp_rdata,
               byte_addr, byte_wdata, byte_we, byte_re
    );

    modport master (
        output req_valid, req_addr, req_wdata, req_length, req_signed,
               req_read, req_write, byte_rdata,
        input  req_ready, resp_valid, resp_rdata,
               byte_addr, byte_wdata, byte_we, byte_re
    );
endinterface
`default_nettype wire

// File: rtl/lsu_byte_sequencer_extend.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_extend
//  Brief    : Sign/zero extension of an assembled load value by access
//             length. Word loads pass through untouched.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [31:0] asm_i,
    input  logic [1:0]  length_i,
    input  logic        signed_i,
    output logic [31:0] data_o
);

    // Select extension width from the latched length; signedness only
    // matters for byte and half loads.
    always_comb begin
        data_o = 32'h0;
        case (length_i)
            LEN_B:   data_o = signed_i ? {{24{asm_i[7]}},  asm_i[7:0]}
                                       : {24'h0,           asm_i[7:0]};
            LEN_H:   data_o = signed_i ? {{16{asm_i[15]}}, asm_i[15:0]}
                                       : {16'h0,           asm_i[15:0]};
            LEN_W:   data_o = asm_i;
            default: data_o = 32'h0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_byte_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_byte_sequencer
//  Brief    : Serialises byte/half/word loads and stores into big-endian
//             single-byte memory transactions, one per cycle, and returns
//             an extended load result with a one-cycle response pulse.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_byte_sequencer
    import lsu_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int MEM_ADDR_W = 6
) (
    input  logic                clock,
    input  logic                reset,
    lsu_byte_sequencer_if.slave bus
);

    localparam logic [0:0] S_IDLE = IDLE;
    localparam logic [0:0] S_XFER = XFER;

    logic [0:0]            state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    logic [MEM_ADDR_W-1:0] base_q;
    logic [1:0]            len_q;
    logic                  write_q;
    logic                  read_q;
    logic                  signed_q;
    logic [31:0]           wdata_q;
    logic [23:0]           asm_q;
    logic                  resp_valid_q;
    logic [31:0]           resp_rdata_q;

    logic                  w_idle;
    logic                  w_xfer;
    logic                  w_accept;
    logic                  w_degen;
    logic [2:0]            w_nbytes;
    logic                  w_last;
    logic [1:0]            w_lane;
    logic [31:0]           w_asm_full;
    logic [31:0]           w_ext;

    // Address bits above the memory port width are ignored by design
    logic                  unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[ADDR_W-1:MEM_ADDR_W];

    assign w_idle   = (state_q == S_IDLE);
    assign w_xfer   = (state_q == S_XFER);
    assign w_accept = bus.req_valid && w_idle;
    // Zero-length or no-op requests complete without touching memory
    assign w_degen  = (len_to_bytes(bus.req_length) == 3'd0) ||
                      (!bus.req_write && !bus.req_read);

    assign w_nbytes   = len_to_bytes(len_q);
    assign w_last     = ({1'b0, idx_q} == (w_nbytes - 3'd1));
    // Big-endian: byte 0 carries the most significant lane of the access
    assign w_lane     = 2'(w_nbytes - 3'd1 - {1'b0, idx_q});
    assign w_asm_full = {asm_q, bus.byte_rdata};

    lsu_extend u_extend (
        .asm_i    (w_asm_full),
        .length_i (len_q),
        .signed_i (signed_q),
        .data_o   (w_ext)
    );

    assign bus.req_ready  = w_idle;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.byte_addr  = base_q + MEM_ADDR_W'(idx_q);
    assign bus.byte_we    = w_xfer && write_q;
    assign bus.byte_re    = w_xfer && read_q;
    assign bus.byte_wdata = (w_xfer && write_q) ? wdata_q[{w_lane, 3'b000} +: 8] : 8'h00;

    // Next state and byte index: enter XFER on a real access, leave after the last byte
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    idx_d = 2'd0;
                    if (!w_degen) state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (w_last) begin
                    state_d = S_IDLE;
                    idx_d   = 2'd0;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 2'd0;
            end
        endcase
    end

    // Latch the request at accept, shift in load bytes, and produce the response pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= 2'd0;
            base_q       <= '0;
            len_q        <= LEN_NONE;
            write_q      <= 1'b0;
            read_q       <= 1'b0;
            signed_q     <= 1'b0;
            wdata_q      <= 32'h0;
            asm_q        <= 24'h0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            resp_valid_q <= 1'b0;
            if (w_accept) begin
                base_q       <= bus.req_addr[MEM_ADDR_W-1:0];
                len_q        <= bus.req_length;
                write_q      <= bus.req_write;
                read_q       <= !bus.req_write && bus.req_read;
                signed_q     <= bus.req_signed;
                wdata_q      <= bus.req_wdata;
                asm_q        <= 24'h0;
                resp_rdata_q <= 32'h0;
                resp_valid_q <= w_degen;
            end else if (w_xfer) begin
                if (read_q) asm_q <= w_asm_full[23:0];
                if (w_last) begin
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= read_q ? w_ext : 32'h0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_byte_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_byte_sequencer
//  Brief    : Directed scoreboard bench for lsu_byte_sequencer with a
//             64-byte behavioural memory on the byte port.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lsu_byte_sequencer;
    import lsu_pkg::*;

    localparam int ADDR_W     = 32;
    localparam int MEM_ADDR_W = 6;

    typedef struct {
        logic [5:0] addr;
        logic       we;
        logic [7:0] data;
    } byte_t;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } resp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    byte_t byte_q[$];
    resp_t resp_q[$];
    logic [7:0] mem [64];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    lsu_byte_sequencer_if #(.ADDR_W(ADDR_W), .MEM_ADDR_W(MEM_ADDR_W)) bus ();

    lsu_byte_sequencer #(.ADDR_W(ADDR_W), .MEM_ADDR_W(MEM_ADDR_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural memory: combinational read, commit on falling edge
    assign bus.byte_rdata = mem[bus.byte_addr];
    always @(negedge clock) begin
        if (bus.byte_we) mem[bus.byte_addr] <= bus.byte_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: byte transactions and responses popped against the scoreboard
    always @(negedge clock) begin : mon
        byte_t bt;
        resp_t rt;
        if (bus.byte_we || bus.byte_re) begin
            if (byte_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL byte_unexpected: addr=%h we=%b re=%b", bus.byte_addr, bus.byte_we, bus.byte_re);
            end else begin
                bt = byte_q.pop_front();
                chk("byte_addr", {26'h0, bus.byte_addr}, {26'h0, bt.addr});
                chk("byte_we_re", {30'h0, bus.byte_we, bus.byte_re}, {30'h0, bt.we, !bt.we});
                if (bt.we) chk("byte_wdata", {24'h0, bus.byte_wdata}, {24'h0, bt.data});
                chk("ready_in_xfer", {31'h0, bus.req_ready}, 32'h0);
            end
        end
        if (bus.resp_valid) begin
            if (resp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_unexpected: rdata=%h cyc=%0d", bus.resp_rdata, cyc);
            end else begin
                rt = resp_q.pop_front();
                chk("resp_rdata", bus.resp_rdata, rt.data);
                chk("resp_cycle", cyc, rt.cyc);
            end
        end
    end

    // Issue one request, push its expected byte transactions and response
    task automatic issue(input logic [31:0] addr, input logic [31:0] wd, input logic [1:0] len,
                         input logic sgn, input logic rd, input logic wr,
                         input logic [31:0] exp, output int k);
        int n;
        int t;
        logic [31:0] sh;
        @(negedge clock);
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        bus.req_length = len;
        bus.req_signed = sgn;
        bus.req_read   = rd;
        bus.req_write  = wr;
        bus.req_valid  = 1'b1;
        t = 0;
        while (!bus.req_ready && t < 100) begin
            @(negedge clock);
            t++;
        end
        if (!bus.req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req_ready=%b after %0d cycles", bus.req_ready, t);
        end
        k = cyc + 1;
        n = (!rd && !wr) ? 0 : int'(len_to_bytes(len));
        resp_q.push_back('{exp, k + n});
        for (int i = 0; i < n; i++) begin
            sh = wd >> ((n - 1 - i) * 8);
            byte_q.push_back('{6'(addr[5:0] + 6'(i)), wr, wr ? sh[7:0] : 8'h00});
        end
        @(posedge clock);
        #1;
        // Scramble request fields: they must be ignored once accepted
        bus.req_valid  = 1'b0;
        bus.req_addr   = 32'hFFFF_FFC5;
        bus.req_wdata  = 32'h5A5A_5A5A;
        bus.req_length = LEN_W;
        bus.req_signed = 1'b1;
        bus.req_read   = 1'b1;
        bus.req_write  = 1'b1;
    endtask

    initial begin
        int k1;
        int k2;
        int t;
        for (int i = 0; i < 64; i++) mem[i] <= 8'(i);
        mem[6'h10] <= 8'h80;
        mem[6'h11] <= 8'h01;
        mem[6'h20] <= 8'h7F;
        mem[6'h21] <= 8'hF0;
        mem[6'h31] <= 8'h11;
        mem[6'h32] <= 8'h22;
        mem[6'h33] <= 8'h33;
        bus.req_valid  = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.req_length = LEN_NONE;
        bus.req_signed = 1'b0;
        bus.req_read   = 1'b0;
        bus.req_write  = 1'b0;

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_req_ready",  {31'h0, bus.req_ready},  32'h1);
        chk("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
        chk("rst_byte_we_re", {30'h0, bus.byte_we, bus.byte_re}, 32'h0);
        chk("rst_byte_addr",  {26'h0, bus.byte_addr},  32'h0);
        chk("rst_byte_wdata", {24'h0, bus.byte_wdata}, 32'h0);
        reset = 1'b0;

        // Word store, big-endian bytes 04..07
        issue(32'h0000_0004, 32'h1122_3344, LEN_W, 1'b0, 1'b0, 1'b1, 32'h0, k1);
        // Half loads, signed and unsigned
        issue(32'h0000_0010, 32'h0, LEN_H, 1'b1, 1'b1, 1'b0, 32'hFFFF_8001, k1);
        issue(32'h0000_0010, 32'h0, LEN_H, 1'b0, 1'b1, 1'b0, 32'h0000_8001, k1);
        // Byte loads
        issue(32'h0000_0020, 32'h0, LEN_B, 1'b1, 1'b1, 1'b0, 32'h0000_007F, k1);
        issue(32'h0000_0021, 32'h0, LEN_B, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFF0, k1);
        issue(32'h0000_0021, 32'h0, LEN_B, 1'b0, 1'b1, 1'b0, 32'h0000_00F0, k1);
        // Address wrap on store then load; upper address bits ignored
        issue(32'h1234_567E, 32'hDEAD_BEEF, LEN_W, 1'b0, 1'b0, 1'b1, 32'h0, k1);
        issue(32'h0000_003E, 32'h0, LEN_W, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, k1);
        // Degenerate requests complete the cycle after accept
        issue(32'h0000_0004, 32'h0, LEN_NONE, 1'b0, 1'b1, 1'b0, 32'h0, k1);
        issue(32'h0000_0004, 32'hFFFF_FFFF, LEN_W, 1'b0, 1'b0, 1'b0, 32'h0, k1);
        // Write wins over read; read back as unsigned half
        issue(32'h0000_0018, 32'h1234_A55A, LEN_H, 1'b0, 1'b1, 1'b1, 32'h0, k1);
        issue(32'h0000_0018, 32'h0, LEN_H, 1'b0, 1'b1, 1'b0, 32'h0000_A55A, k1);

        // Reset abort partway through a word store to 0x08
        @(negedge clock);
        bus.req_addr   = 32'h0000_0008;
        bus.req_wdata  = 32'hAABB_CCDD;
        bus.req_length = LEN_W;
        bus.req_signed = 1'b0;
        bus.req_read   = 1'b0;
        bus.req_write  = 1'b1;
        bus.req_valid  = 1'b1;
        t = 0;
        while (!bus.req_ready && t < 100) begin
            @(negedge clock);
            t++;
        end
        chk("abort_ready_before", {31'h0, bus.req_ready}, 32'h1);
        byte_q.push_back('{6'h08, 1'b1, 8'hAA});
        byte_q.push_back('{6'h09, 1'b1, 8'hBB});
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("abort_req_ready", {31'h0, bus.req_ready}, 32'h1);
        chk("abort_byte_we",   {31'h0, bus.byte_we},   32'h0);
        @(negedge clock);
        reset = 1'b0;
        chk("abort_mem08", {24'h0, mem[6'h08]}, 32'hAA);
        chk("abort_mem09", {24'h0, mem[6'h09]}, 32'hBB);
        chk("abort_mem0A", {24'h0, mem[6'h0A]}, 32'h0A);
        chk("abort_mem0B", {24'h0, mem[6'h0B]}, 32'h0B);

        // Back-to-back: byte store then word load with no idle gap
        issue(32'h0000_0030, 32'h0000_005C, LEN_B, 1'b0, 1'b0, 1'b1, 32'h0, k1);
        issue(32'h0000_0030, 32'h0, LEN_W, 1'b0, 1'b1, 1'b0, 32'h5C11_2233, k2);
        chk("b2b_accept_gap", k2, k1 + 2);

        // Drain the scoreboard with a bounded wait
        t = 0;
        while ((byte_q.size() != 0 || resp_q.size() != 0) && t < 100) begin
            @(negedge clock);
            t++;
        end
        repeat (4) @(negedge clock);
        chk("byte_q_empty", byte_q.size(), 32'h0);
        chk("resp_q_empty", resp_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
